quad4_grad_engine: RTL and testbench

QUAD4_GRAD_ENGINE -- requirements
Module: quad4_grad_engine

---
 rtl/grad_pkg.sv | 53 +++++
 rtl/fixed_mul_sat.sv | 38 +++
 rtl/quad4_grad_engine.sv | 157 +++++++++++++++
 tb/tb_quad4_grad_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/grad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grad_pkg
// Brief    : Q-format widths, saturation limits and FSM encoding for the
//            quadratic gradient engine.
// Revision : 1.0 - initial release
// ============================================================================
package grad_pkg;

    localparam int c_Q_W    = 16;
    localparam int c_GRAD_W = 18;
    localparam int c_VAL_W  = 32;
    localparam int c_ACC_W  = 40;
    localparam int c_LR_W   = 32;
    localparam int c_FRAC_W = 8;
    // 4b+a spans 5*2^15 at the input extremes, one bit beyond c_GRAD_W
    localparam int c_MUL_A_W = c_GRAD_W + 1;

    localparam logic signed [c_Q_W-1:0]   c_Q_MAX   = 16'sh7FFF;
    localparam logic signed [c_Q_W-1:0]   c_Q_MIN   = 16'sh8000;
    localparam logic signed [c_VAL_W-1:0] c_VAL_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [c_VAL_W-1:0] c_VAL_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VAL  = 3'd1,
        ST_STEP = 3'd2,
        ST_PACK = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic q_oor(input logic signed [c_ACC_W-1:0] x);
        return (x > c_ACC_W'(c_Q_MAX)) || (x < c_ACC_W'(c_Q_MIN));
    endfunction

    function automatic logic signed [c_Q_W-1:0] q_sat(input logic signed [c_ACC_W-1:0] x);
        if (x > c_ACC_W'(c_Q_MAX)) return c_Q_MAX;
        if (x < c_ACC_W'(c_Q_MIN)) return c_Q_MIN;
        return x[c_Q_W-1:0];
    endfunction

    function automatic logic val_oor(input logic signed [c_ACC_W-1:0] x);
        return (x > c_ACC_W'(c_VAL_MAX)) || (x < c_ACC_W'(c_VAL_MIN));
    endfunction

    function automatic logic signed [c_VAL_W-1:0] val_sat(input logic signed [c_ACC_W-1:0] x);
        if (x > c_ACC_W'(c_VAL_MAX)) return c_VAL_MAX;
        if (x < c_ACC_W'(c_VAL_MIN)) return c_VAL_MIN;
        return x[c_VAL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_mul_sat.sv
`default_nettype none
// ============================================================================
// Module   : fixed_mul_sat
// Brief    : Signed fixed-point multiply, arithmetic right shift by FRAC,
//            saturation to OUT_W bits with a saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_mul_sat #(
    parameter int A_W   = 19,
    parameter int B_W   = 32,
    parameter int OUT_W = 40,
    parameter int FRAC  = 8
) (
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [OUT_W-1:0] o_p,
    output logic                    o_sat
);

    localparam int c_PROD_W = A_W + B_W;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_shift;
    logic [c_PROD_W-OUT_W:0]    w_top;

    assign w_prod  = c_PROD_W'(i_a) * c_PROD_W'(i_b);
    assign w_shift = w_prod >>> FRAC;

    // Result fits when every bit above the output sign bit repeats it
    assign w_top = w_shift[c_PROD_W-1:OUT_W-1];
    assign o_sat = !((&w_top) || !(|w_top));

    assign o_p = o_sat ? (w_shift[c_PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                              : {1'b0, {(OUT_W-1){1'b1}}})
                       : w_shift[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/quad4_grad_engine.sv
`default_nettype none
// ============================================================================
// Module   : quad4_grad_engine
// Brief    : Evaluates f = a^2 + 2b^2 + c^2 + d^2 + ab and its scaled gradient
//            step on one shared multiplier, fixed latency of 10 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module quad4_grad_engine
    import grad_pkg::*;
#(
    parameter logic signed [c_LR_W-1:0] LEARNING_RATE = 32'sh0000_0020
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_func,
    input  logic [c_Q_W-1:0]   a_in,
    input  logic [c_Q_W-1:0]   b_in,
    input  logic [c_Q_W-1:0]   c_in,
    input  logic [c_Q_W-1:0]   d_in,
    output logic [c_VAL_W-1:0] value,
    output logic [c_Q_W-1:0]   a_diff_out,
    output logic [c_Q_W-1:0]   b_diff_out,
    output logic [c_Q_W-1:0]   c_diff_out,
    output logic [c_Q_W-1:0]   d_diff_out,
    output logic               func_done,
    output logic               overflow
);

    state_t                      r_state, w_next;
    logic [2:0]                  r_cnt;
    logic signed [c_Q_W-1:0]     r_a, r_b, r_c, r_d;
    logic signed [c_ACC_W-1:0]   r_acc;
    logic signed [c_Q_W-1:0]     r_step [4];
    logic                        r_ovf_run;
    logic signed [c_VAL_W-1:0]   r_value;
    logic signed [c_Q_W-1:0]     r_diff_a, r_diff_b, r_diff_c, r_diff_d;
    logic                        r_overflow;

    logic signed [c_MUL_A_W-1:0] w_ga, w_gb, w_gc, w_gd, w_mul_a;
    logic signed [c_LR_W-1:0]    w_mul_b;
    logic signed [c_ACC_W-1:0]   w_prod;
    logic                        w_mul_sat;

    assign w_ga = (c_MUL_A_W'(r_a) <<< 1) + c_MUL_A_W'(r_b);
    assign w_gb = (c_MUL_A_W'(r_b) <<< 2) + c_MUL_A_W'(r_a);
    assign w_gc = c_MUL_A_W'(r_c) <<< 1;
    assign w_gd = c_MUL_A_W'(r_d) <<< 1;

    // VAL walks a*a, b*b, c*c, d*d, a*b; STEP walks ga, gb, gc, gd times the rate
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        if (r_state == ST_VAL) begin
            case (r_cnt)
                3'd0:    begin w_mul_a = c_MUL_A_W'(r_a); w_mul_b = c_LR_W'(r_a); end
                3'd1:    begin w_mul_a = c_MUL_A_W'(r_b); w_mul_b = c_LR_W'(r_b); end
                3'd2:    begin w_mul_a = c_MUL_A_W'(r_c); w_mul_b = c_LR_W'(r_c); end
                3'd3:    begin w_mul_a = c_MUL_A_W'(r_d); w_mul_b = c_LR_W'(r_d); end
                default: begin w_mul_a = c_MUL_A_W'(r_a); w_mul_b = c_LR_W'(r_b); end
            endcase
        end else begin
            w_mul_b = LEARNING_RATE;
            case (r_cnt)
                3'd0:    w_mul_a = w_ga;
                3'd1:    w_mul_a = w_gb;
                3'd2:    w_mul_a = w_gc;
                default: w_mul_a = w_gd;
            endcase
        end
    end

    fixed_mul_sat #(
        .A_W   (c_MUL_A_W),
        .B_W   (c_LR_W),
        .OUT_W (c_ACC_W),
        .FRAC  (c_FRAC_W)
    ) u_mul (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_p   (w_prod),
        .o_sat (w_mul_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_func)     w_next = ST_VAL;
            ST_VAL:  if (r_cnt == 3'd4)  w_next = ST_STEP;
            ST_STEP: if (r_cnt == 3'd3)  w_next = ST_PACK;
            ST_PACK:                     w_next = ST_DONE;
            ST_DONE: if (!start_func)    w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_acc      <= '0;
            r_ovf_run  <= 1'b0;
            r_value    <= '0;
            r_diff_a   <= '0;
            r_diff_b   <= '0;
            r_diff_c   <= '0;
            r_diff_d   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < 4; i++) r_step[i] <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
            case (r_state)
                ST_IDLE: if (start_func) begin
                    r_a        <= a_in;
                    r_b        <= b_in;
                    r_c        <= c_in;
                    r_d        <= d_in;
                    r_acc      <= '0;
                    r_ovf_run  <= 1'b0;
                    r_overflow <= 1'b0;
                end
                // b*b is weighted twice in f
                ST_VAL:  r_acc <= r_acc + ((r_cnt == 3'd1) ? (w_prod <<< 1) : w_prod);
                ST_STEP: begin
                    r_step[r_cnt[1:0]] <= q_sat(w_prod);
                    r_ovf_run          <= r_ovf_run | w_mul_sat | q_oor(w_prod);
                end
                ST_PACK: begin
                    r_value    <= val_sat(r_acc);
                    r_diff_a   <= r_step[0];
                    r_diff_b   <= r_step[1];
                    r_diff_c   <= r_step[2];
                    r_diff_d   <= r_step[3];
                    r_overflow <= r_ovf_run | val_oor(r_acc);
                end
                default: ;
            endcase
        end
    end

    assign value      = r_value;
    assign a_diff_out = r_diff_a;
    assign b_diff_out = r_diff_b;
    assign c_diff_out = r_diff_c;
    assign d_diff_out = r_diff_d;
    assign overflow   = r_overflow;
    assign func_done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_quad4_grad_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad4_grad_engine
// Brief    : Scoreboard bench for quad4_grad_engine at two learning rates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad4_grad_engine;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_func = 1'b0;
    logic        start_hi   = 1'b0;
    logic [15:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;

    logic [31:0] value, value_hi;
    logic [15:0] a_diff, b_diff, c_diff, d_diff;
    logic [15:0] a_diff_hi, b_diff_hi, c_diff_hi, d_diff_hi;
    logic        func_done, func_done_hi, overflow, overflow_hi;

    typedef struct {
        logic [31:0] v;
        logic [63:0] diffs;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] expv;
    } chk_t;

    exp_t exp_q[$];
    exp_t exp_hi_q[$];
    chk_t chk_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    quad4_grad_engine dut (
        .clk(clk), .rst_n(rst_n), .start_func(start_func),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .value(value), .a_diff_out(a_diff), .b_diff_out(b_diff),
        .c_diff_out(c_diff), .d_diff_out(d_diff),
        .func_done(func_done), .overflow(overflow)
    );

    quad4_grad_engine #(.LEARNING_RATE(32'sh0000_0100)) dut_hi (
        .clk(clk), .rst_n(rst_n), .start_func(start_hi),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .value(value_hi), .a_diff_out(a_diff_hi), .b_diff_out(b_diff_hi),
        .c_diff_out(c_diff_hi), .d_diff_out(d_diff_hi),
        .func_done(func_done_hi), .overflow(overflow_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp_one(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic check_res(input exp_t e, input logic [31:0] v, input logic [63:0] dfs, input logic ovf);
        cmp_one({e.name, ".value"},    64'(v),   64'(e.v));
        cmp_one({e.name, ".diffs"},    dfs,      e.diffs);
        cmp_one({e.name, ".overflow"}, 64'(ovf), 64'(e.ovf));
        cmp_one({e.name, ".latency"},  64'(cyc), 64'(e.due));
    endtask

    // Monitor: every rising func_done pops one expected result
    initial begin : monitor
        exp_t e;
        chk_t c;
        logic dd = 1'b0;
        logic dh = 1'b0;
        forever begin
            @(negedge clk);
            if (func_done === 1'b1 && !dd) begin
                if (exp_q.size() == 0) cmp_one("spurious_done", 64'(func_done), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check_res(e, value, {a_diff, b_diff, c_diff, d_diff}, overflow);
                end
            end
            if (func_done_hi === 1'b1 && !dh) begin
                if (exp_hi_q.size() == 0) cmp_one("spurious_done_hi", 64'(func_done_hi), 64'd0);
                else begin
                    e = exp_hi_q.pop_front();
                    check_res(e, value_hi, {a_diff_hi, b_diff_hi, c_diff_hi, d_diff_hi}, overflow_hi);
                end
            end
            dd = (func_done === 1'b1);
            dh = (func_done_hi === 1'b1);
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                cmp_one(c.name, c.act, c.expv);
            end
        end
    end

    task automatic push_chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        chk_t c;
        c.name = nm;
        c.act  = act;
        c.expv = expv;
        chk_q.push_back(c);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input bit hi, input bit track,
                         input logic [31:0] v, input logic [15:0] da, input logic [15:0] db,
                         input logic [15:0] dc, input logic [15:0] ddv, input logic ovf,
                         input string nm);
        exp_t e;
        @(negedge clk);
        a_in = a; b_in = b; c_in = c; d_in = d;
        if (hi) start_hi = 1'b1;
        else    start_func = 1'b1;
        if (track) begin
            e.v     = v;
            e.diffs = {da, db, dc, ddv};
            e.ovf   = ovf;
            e.due   = cyc + 11;
            e.name  = nm;
            if (hi) exp_hi_q.push_back(e);
            else    exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input bit hi, input string nm);
        int n = 0;
        while (((hi ? func_done_hi : func_done) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        push_chk({nm, ".done_seen"}, 64'(hi ? func_done_hi : func_done), 64'd1);
    endtask

    task automatic release_start(input bit hi);
        @(negedge clk);
        if (hi) start_hi = 1'b0;
        else    start_func = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input bit hi, input logic [31:0] v,
                       input logic [15:0] da, input logic [15:0] db, input logic [15:0] dc,
                       input logic [15:0] ddv, input logic ovf, input string nm);
        issue(a, b, c, d, hi, 1'b1, v, da, db, dc, ddv, ovf, nm);
        wait_done(hi, nm);
        release_start(hi);
    endtask

    initial begin : driver
        repeat (3) @(negedge clk);
        push_chk("reset.value", 64'(value), 64'd0);
        push_chk("reset.diffs", {a_diff, b_diff, c_diff, d_diff}, 64'd0);
        push_chk("reset.func_done", 64'(func_done), 64'd0);
        push_chk("reset.overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        run(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, "zero");
        run(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 32'h0000_0100, 16'h0040, 16'h0020, 16'h0000, 16'h0000, 1'b0, "unit_a");
        run(16'h0200, 16'hFF00, 16'h0080, 16'h0000, 0, 32'h0000_0440, 16'h0060, 16'hFFC0, 16'h0020, 16'h0000, 1'b0, "mixed");
        run(16'h0000, 16'h0000, 16'h0100, 16'hFF00, 0, 32'h0000_0200, 16'h0000, 16'h0000, 16'h0040, 16'hFFC0, 1'b0, "cd");
        run(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 32'h0000_0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, "floor");

        run(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 32'h017F_FA00, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "hi_pos");
        run(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 32'h0180_0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, "hi_neg");
        run(16'h0100, 16'h0000, 16'h0000, 16'h0000, 1, 32'h0000_0100, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 1'b0, "hi_clear");

        // start held past DONE, then dropped, then re-raised
        issue(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 32'h0000_0100, 16'h0040, 16'h0020, 16'h0000, 16'h0000, 1'b0, "hold");
        wait_done(0, "hold");
        repeat (4) begin
            @(negedge clk);
            push_chk("hold.func_done", 64'(func_done), 64'd1);
        end
        start_func = 1'b0;
        @(negedge clk);
        push_chk("drop.func_done", 64'(func_done), 64'd0);
        run(16'h0200, 16'hFF00, 16'h0080, 16'h0000, 0, 32'h0000_0440, 16'h0060, 16'hFFC0, 16'h0020, 16'h0000, 1'b0, "reraise");

        // start pulsed low and inputs disturbed mid-run
        issue(16'h0000, 16'h0000, 16'h0100, 16'hFF00, 0, 1'b1, 32'h0000_0200, 16'h0000, 16'h0000, 16'h0040, 16'hFFC0, 1'b0, "pulse");
        repeat (3) @(negedge clk);
        start_func = 1'b0;
        a_in = 16'h7FFF; b_in = 16'h7FFF; c_in = 16'h7FFF; d_in = 16'h7FFF;
        @(negedge clk);
        start_func = 1'b1;
        wait_done(0, "pulse");
        release_start(0);

        // reset mid-run aborts without a func_done
        issue(16'h0200, 16'hFF00, 16'h0080, 16'h0000, 0, 1'b0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, "abort");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        push_chk("abort.value", 64'(value), 64'd0);
        push_chk("abort.diffs", {a_diff, b_diff, c_diff, d_diff}, 64'd0);
        push_chk("abort.func_done", 64'(func_done), 64'd0);
        push_chk("abort.overflow", 64'(overflow), 64'd0);
        start_func = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        run(16'h0200, 16'hFF00, 16'h0080, 16'h0000, 0, 32'h0000_0440, 16'h0060, 16'hFFC0, 16'h0020, 16'h0000, 1'b0, "post_reset");

        push_chk("scoreboard.pending", 64'(exp_q.size() + exp_hi_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
